// File: rtl/tm1638_fifo_writer.sv
// tm1638_fifo_writer
//   Drains 18-bit command words from a show-ahead FIFO and shifts them out on
//   the TM1638 three-wire bus (STB active-low, CLK idles high, DIO write-only).
//   Word layout: [7:0] byte 0, [15:8] byte 1, [16] TWO (send byte 1 too),
//   [17] LAST (release STB after this word). Bits go out LSB first; the
//   TM1638 samples DIO on the rising edge of o_Sclk.
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_Empty        FIFO empty flag
//   o_Read         one-cycle pop strobe to the FIFO
//   i_Data         FIFO head word, valid while i_Empty = 0
//   o_Stb          TM1638 STB (active-low)
//   o_Sclk         TM1638 CLK (idles high)
//   o_Dio          TM1638 DIO (idles high)
//   o_Busy         frame open or inter-frame STB gap running
//   o_Diag_State   (TM1638_FIFO_WRITER_DIAG_EN only) current FSM state code
//   o_Diag_Bit_Cnt (TM1638_FIFO_WRITER_DIAG_EN only) current bit index
//
// Optional build macro: TM1638_FIFO_WRITER_DIAG_EN adds the two diag ports.
//
// state  | meaning
// IDLE   | waiting for a word; STB stays low if the frame is still open
// LOAD   | pop strobe; capture word; STB asserted at the closing edge
// BIT_LO | SCLK low for CLK_DIV cycles, DIO shows current bit
// BIT_HI | SCLK high for CLK_DIV cycles, target samples DIO
// HOLD   | SCLK high for CLK_DIV cycles after a byte
// GAP    | STB high for STB_GAP cycles between frames

module tm1638_fifo_writer #(
  parameter int DATA_WIDTH = 18,
  parameter int CLK_DIV    = 4,
  parameter int STB_GAP    = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Empty,
  output logic                  o_Read,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_Stb,
  output logic                  o_Sclk,
  output logic                  o_Dio,
  output logic                  o_Busy
`ifdef TM1638_FIFO_WRITER_DIAG_EN
  ,
  output logic [2:0]            o_Diag_State,
  output logic [2:0]            o_Diag_Bit_Cnt
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (STB_GAP > 1) ? $clog2(STB_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STB_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_BIT_LO = 3'd2,
    S_BIT_HI = 3'd3,
    S_HOLD   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_byte1;
  logic             r_two;
  logic             r_last;
  logic             r_second;
  logic             w_second_nxt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_nxt;
  logic             w_div_tc;

  logic r_stb, r_sclk, r_dio, r_read, r_busy;
  logic w_stb_nxt, w_sclk_nxt, w_dio_nxt, w_read_nxt, w_busy_nxt;

  assign w_div_tc = (r_div == '0);

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath next values and next output values
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_second_nxt  = r_second;
    case (r_state)
      S_IDLE: begin
        if (!i_Empty) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt   = S_BIT_LO;
        w_shift_nxt   = i_Data[7:0];
        w_bit_cnt_nxt = 3'd0;
        w_second_nxt  = 1'b0;
      end
      S_BIT_LO: begin
        if (w_div_tc) w_state_nxt = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (w_div_tc) begin
          // 3-bit counter wraps to 0 after bit 7, ready for the next byte
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_BIT_LO;
            w_shift_nxt = {1'b1, r_shift[7:1]};
          end
        end
      end
      S_HOLD: begin
        if (w_div_tc) begin
          if (!r_second && r_two) begin
            w_state_nxt  = S_BIT_LO;
            w_shift_nxt  = r_byte1;
            w_second_nxt = 1'b1;
          end else if (r_last) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    w_stb_nxt = r_stb;
    if (w_state_nxt == S_BIT_LO) w_stb_nxt = 1'b0;
    if (w_state_nxt == S_GAP)    w_stb_nxt = 1'b1;
    w_sclk_nxt = (w_state_nxt != S_BIT_LO);
    w_dio_nxt  = ((w_state_nxt == S_BIT_LO) || (w_state_nxt == S_BIT_HI)) ?
                 w_shift_nxt[0] : 1'b1;
    w_read_nxt = (w_state_nxt == S_LOAD);
    w_busy_nxt = !w_stb_nxt || (w_state_nxt == S_GAP);
  end

  // Datapath, timers and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_div     <= DIV_LOAD;
      r_gap     <= GAP_LOAD;
      r_shift   <= '0;
      r_byte1   <= '0;
      r_two     <= 1'b0;
      r_last    <= 1'b0;
      r_second  <= 1'b0;
      r_bit_cnt <= 3'd0;
      r_stb     <= 1'b1;
      r_sclk    <= 1'b1;
      r_dio     <= 1'b1;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_second  <= w_second_nxt;
      if (r_state == S_LOAD) begin
        r_byte1 <= i_Data[15:8];
        r_two   <= i_Data[16];
        r_last  <= i_Data[17];
      end
      // Half-period down-counter, reloaded on every state change
      if (w_state_nxt != r_state) begin
        r_div <= DIV_LOAD;
      end else if (!w_div_tc) begin
        r_div <= r_div - DIV_W'(1);
      end
      if ((w_state_nxt == S_GAP) && (r_state != S_GAP)) begin
        r_gap <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap != '0)) begin
        r_gap <= r_gap - GAP_W'(1);
      end
      r_stb  <= w_stb_nxt;
      r_sclk <= w_sclk_nxt;
      r_dio  <= w_dio_nxt;
      r_read <= w_read_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  assign o_Stb  = r_stb;
  assign o_Sclk = r_sclk;
  assign o_Dio  = r_dio;
  assign o_Read = r_read;
  assign o_Busy = r_busy;

`ifdef TM1638_FIFO_WRITER_DIAG_EN
  assign o_Diag_State   = r_state;
  assign o_Diag_Bit_Cnt = r_bit_cnt;
`endif

endmodule

// File: tb/tb_tm1638_fifo_writer.sv
// Bench for tm1638_fifo_writer: a queue-based FIFO model feeds the DUT, and a
// bus decoder turns STB/SCLK/DIO back into bytes and frame ends, which are
// compared against the byte/frame list derived from the pushed words.

module tb_tm1638_fifo_writer;

  localparam int DW      = 18;
  localparam int CLK_DIV = 4;
  localparam int STB_GAP = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] data  = '0;
  logic          rd, stb, sclk, dio, busy;
`ifdef TM1638_FIFO_WRITER_DIAG_EN
  logic [2:0]    diag_state, diag_bit;
  logic [2:0]    prev_diag = 3'd0;
  int            bad_diag  = 0;
`endif

  always #5 clk = ~clk;

  tm1638_fifo_writer #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CLK_DIV),
    .STB_GAP   (STB_GAP)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .i_Empty(empty),
    .o_Read (rd),
    .i_Data (data),
    .o_Stb  (stb),
    .o_Sclk (sclk),
    .o_Dio  (dio),
    .o_Busy (busy)
`ifdef TM1638_FIFO_WRITER_DIAG_EN
    ,
    .o_Diag_State  (diag_state),
    .o_Diag_Bit_Cnt(diag_bit)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // FIFO contents and expected bus traffic (byte values, -1 = STB release)
  logic [DW-1:0] fifo_q[$];
  int            exp_q[$];

  // Bus decoder state
  logic       s_stb, s_sclk, s_dio, s_read, s_busy, s_empty;
  logic       prev_stb  = 1'b1;
  logic       prev_sclk = 1'b1;
  logic [7:0] acc       = '0;
  int         nbits = 0, frame_bytes = 0, lo_cnt = 0, hi_cnt = 1000;
  bit         seen_frame = 1'b0;
  int         n_pops = 0, n_pushes = 0, bad_busy = 0;

`ifdef TM1638_FIFO_WRITER_DIAG_EN
  function automatic bit diag_step_ok(input logic [2:0] a, input logic [2:0] b);
    case (a)
      3'd0:    return b == 3'd1;
      3'd1:    return b == 3'd2;
      3'd2:    return b == 3'd3;
      3'd3:    return (b == 3'd2) || (b == 3'd4);
      3'd4:    return (b == 3'd0) || (b == 3'd2) || (b == 3'd5);
      3'd5:    return b == 3'd0;
      default: return 1'b0;
    endcase
  endfunction
`endif

  task automatic drive_fifo();
    empty = (fifo_q.size() == 0);
    data  = empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    n_pushes++;
    exp_q.push_back(int'(w[7:0]));
    if (w[16]) exp_q.push_back(int'(w[15:8]));
    if (w[17]) exp_q.push_back(-1);
    drive_fifo();
  endtask

  // One clock: sample at negedge, decode the bus, apply any pop after posedge
  task automatic tick();
    int e;
    @(negedge clk);
    s_stb = stb; s_sclk = sclk; s_dio = dio; s_read = rd; s_busy = busy; s_empty = empty;
    if (s_read) begin
      n_pops++;
      check_val("read_while_empty", int'(s_empty), 0);
    end
    if (prev_stb && !s_stb) begin
      if (seen_frame) check_val("stb_gap_ge_min", int'(hi_cnt >= STB_GAP + 2), 1);
      lo_cnt = 0; frame_bytes = 0; nbits = 0;
    end
    if (!prev_stb && s_stb) begin
      check_val("partial_byte_at_stb_rise", nbits, 0);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -2;
      check_val("frame_end", e, -1);
      if (frame_bytes == 1) check_val("stb_low_len", lo_cnt, 17 * CLK_DIV);
      hi_cnt = 0; seen_frame = 1'b1;
    end
    if (!prev_sclk && s_sclk && !s_stb) begin
      acc = {s_dio, acc[7:1]};
      nbits++;
      if (nbits == 8) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -2;
        check_val("byte", int'(acc), e);
        frame_bytes++;
        nbits = 0;
      end
    end
    if (s_stb) begin
      if (hi_cnt < 1000) hi_cnt++;
    end else begin
      lo_cnt++;
    end
    if (s_busy != ((!s_stb) || (hi_cnt <= STB_GAP))) bad_busy++;
`ifdef TM1638_FIFO_WRITER_DIAG_EN
    if (diag_state != prev_diag && !diag_step_ok(prev_diag, diag_state)) bad_diag++;
    prev_diag = diag_state;
`endif
    prev_stb = s_stb; prev_sclk = s_sclk;
    @(posedge clk);
    #1;
    if (s_read && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < 20000) begin
      tick();
      n++;
    end
    check_val(tag, int'(n < 20000), 1);
  endtask

  initial begin
    int bad, pops0, n;
    logic [DW-1:0] w;

    // Reset values
    rst_n = 1'b0;
    drive_fifo();
    tick();
    check_val("rst_stb", int'(s_stb), 1);
    check_val("rst_sclk", int'(s_sclk), 1);
    check_val("rst_dio", int'(s_dio), 1);
    check_val("rst_read", int'(s_read), 0);
    check_val("rst_busy", int'(s_busy), 0);
    rst_n = 1'b1;

    // Idle with FIFO empty
    bad = 0;
    repeat (50) begin
      tick();
      if (!s_stb || !s_sclk || !s_dio || s_read || s_busy) bad++;
    end
    check_val("idle_quiet", bad, 0);

    // Single LAST byte; pop latency
    pops0 = n_pops;
    push(18'h2_0044);
    tick(); check_val("pop_lat_n", int'(s_read), 0);
    tick(); check_val("pop_lat_n1", int'(s_read), 1);
    tick(); check_val("stb_fall_n2", int'(s_stb), 0);
    drain("drain_single");
    check_val("pops_single", n_pops - pops0, 1);

    // Two-byte open word followed by closing word
    pops0 = n_pops;
    push(18'h1_C040);
    push(18'h2_0088);
    drain("drain_two_words");
    check_val("pops_two_words", n_pops - pops0, 2);

    // Open frame held across an empty FIFO
    push(18'h0_0040);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i >= 2 && s_stb) bad++;
      if (i >= 100 && (!s_sclk || !s_dio)) bad++;
    end
    check_val("open_frame_hold", bad, 0);
    check_val("open_frame_byte_sent", exp_q.size(), 0);
    push(18'h2_00FF);
    drain("drain_open_frame");

    // Reset mid-byte: during bit 3 of 0x55
    push(18'h2_0055);
    n = 0;
    while (nbits < 3 && n < 500) begin tick(); n++; end
    while (s_sclk && n < 500) begin tick(); n++; end
    check_val("reach_bit3", int'(n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_stb", int'(stb), 1);
    check_val("async_rst_sclk", int'(sclk), 1);
    check_val("async_rst_dio", int'(dio), 1);
    check_val("async_rst_busy", int'(busy), 0);
    exp_q.delete();
    nbits = 0; frame_bytes = 0; lo_cnt = 0; hi_cnt = 1000; seen_frame = 1'b0;
    prev_stb = 1'b1; prev_sclk = 1'b1;
`ifdef TM1638_FIFO_WRITER_DIAG_EN
    prev_diag = 3'd0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    push(18'h2_00A5);
    drain("drain_after_reset");

    // Eight words queued at once
    pops0 = n_pops;
    for (int i = 0; i < 8; i++) begin
      w = DW'($urandom);
      w[17] = (i == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      push(w);
    end
    drain("drain_eight");
    check_val("pops_eight", n_pops - pops0, 8);

    // Random words with random spacing
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(2, 8));
      for (int i = 0; i < n; i++) begin
        w = DW'($urandom);
        if (i == n - 1) w[17] = 1'b1;
        push(w);
        repeat ($urandom_range(0, 30)) tick();
      end
      drain("drain_random");
    end

    check_val("busy_tracking", bad_busy, 0);
    check_val("pops_total", n_pops, n_pushes);
`ifdef TM1638_FIFO_WRITER_DIAG_EN
    check_val("diag_state_seq", bad_diag, 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
